// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Decoupled instruction fetch stage. Generates sequential fetch
//             addresses, issues them to a pipelined in-order instruction
//             memory, and buffers returned instructions (with their PC+INC)
//             in a DEPTH-entry queue in front of decode. Supports decode
//             back-pressure, several outstanding requests, halt, and
//             flush-on-redirect with discard of in-flight responses.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             imem_req/addr/rdy              - request channel to memory
//             imem_rsp_valid/data            - in-order response channel
//             ALU_Out, PC_Next               - redirect targets
//             RegToPc/SIIC/PCSrc/Halt_cntrl  - redirect and halt controls
//             Instruction, PC_Inc, inst_valid, inst_ready - decode handshake
//             Valid_PC                       - fetch PC is non-zero
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int                 WIDTH    = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter logic [WIDTH-1:0]   SIIC_VEC = WIDTH'(2),
    parameter logic [WIDTH-1:0]   INC      = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rdy,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic [WIDTH-1:0] PC_Next,
    input  logic             RegToPc_cntrl,
    input  logic             SIIC_cntrl,
    input  logic             PCSrc_cntrl,
    input  logic             Halt_cntrl,
    output logic [WIDTH-1:0] Instruction,
    output logic [WIDTH-1:0] PC_Inc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic             Valid_PC
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [CW:0]   c_depth   = (CW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_discard;

    // Instruction queue
    logic [WIDTH-1:0] r_q_instr [DEPTH];
    logic [WIDTH-1:0] r_q_pcinc [DEPTH];
    logic [AW-1:0]    r_q_rd;
    logic [AW-1:0]    r_q_wr;

    // Issue-PC shadow FIFO: one entry per outstanding request, popped on
    // every response (kept or discarded) so it stays aligned with memory.
    logic [WIDTH-1:0] r_s_pc [DEPTH];
    logic [AW-1:0]    r_s_rd;
    logic [AW-1:0]    r_s_wr;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_redirect;
    logic [WIDTH-1:0] w_target;
    logic [CW:0]      w_inflight;
    logic             w_room;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    assign w_redirect = RegToPc_cntrl | SIIC_cntrl | PCSrc_cntrl;

    always_comb begin
        w_target = PC_Next;
        if (RegToPc_cntrl) begin
            w_target = ALU_Out;
        end else if (SIIC_cntrl) begin
            w_target = SIIC_VEC;
        end
    end

    // Queued plus in-flight must never exceed DEPTH so every response
    // has a guaranteed slot.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_room     = (w_inflight < c_depth);

    assign imem_req  = ~rst & ~Halt_cntrl & ~w_redirect & w_room;
    assign imem_addr = r_fetch_pc;
    assign w_issue   = imem_req & imem_rdy;

    assign inst_valid = (r_count != '0);
    assign w_drop     = imem_rsp_valid & (r_discard != '0);
    // A redirect flushes the queue, so neither a push nor a pop can land
    // in that cycle; the arriving response is folded into the discard.
    assign w_push     = imem_rsp_valid & (r_discard == '0) & ~w_redirect;
    assign w_pop      = inst_valid & inst_ready & ~w_redirect;

    assign Instruction = r_q_instr[r_q_rd];
    assign PC_Inc      = r_q_pcinc[r_q_rd];
    assign Valid_PC    = |r_fetch_pc;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_q_rd        <= '0;
            r_q_wr        <= '0;
            r_s_rd        <= '0;
            r_s_wr        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(imem_rsp_valid);

            if (w_issue) begin
                r_s_wr <= r_s_wr + c_ptr_one;
            end
            if (imem_rsp_valid) begin
                r_s_rd <= r_s_rd + c_ptr_one;
            end

            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_count    <= '0;
                r_q_rd     <= r_q_wr;
                r_discard  <= r_outstanding - CW'(imem_rsp_valid);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + INC;
                end
                if (w_drop) begin
                    r_discard <= r_discard - c_cnt_one;
                end
                if (w_push) begin
                    r_q_wr <= r_q_wr + c_ptr_one;
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + c_ptr_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage arrays (contents are don't-care until their valid flags say
    // otherwise, so they carry no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_s_pc[r_s_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_instr[r_q_wr] <= imem_rsp_data;
            r_q_pcinc[r_q_wr] <= r_s_pc[r_s_rd] + INC;
        end
    end

endmodule
`default_nettype wire
